ray_dispatcher: RTL and testbench

- Producer side of the ray core's primary-fragment input interface (`add_input` / `input_data` / `fifo_full`).
- Raster-scans one frame of `SCREEN_WIDTH` x `SCREEN_HEIGHT` pixel positions and pushes one `SurfaceInputData` per pixel into the ray core, honouring `fifo_full` backpressure.
- Then watches the core's `pixel_counter` until all fragments have been shaded, and signals frame completion to the host/frame controller.
- Owns the `reset_pixel_counter` pulse at frame start.

---
 rtl/ray_dispatcher_pkg.sv | 34 +++
 rtl/ray_dispatcher_raster_counter.sv | 47 ++++
 rtl/ray_dispatcher.sv | 94 +++++++++
 tb/tb_ray_dispatcher.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_dispatcher_pkg.sv
// Shared types for the ray core front end: fragment/render records, dispatcher
// state encodings and default screen geometry.
package ray_dispatcher_pkg;

  localparam int SCREEN_WIDTH_DEF  = 160;
  localparam int SCREEN_HEIGHT_DEF = 120;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] depth;
    logic [15:0] prim_id;
    logic [7:0]  flags;
  } SurfaceInputData;

  typedef struct packed {
    logic        frame_active;
    logic [31:0] frame_count;
  } RenderState;

  typedef logic [2:0] disp_state_t;

  localparam disp_state_t S_IDLE     = 3'd0;
  localparam disp_state_t S_CLEAR    = 3'd1;
  localparam disp_state_t S_DISPATCH = 3'd2;
  localparam disp_state_t S_DRAIN    = 3'd3;
  localparam disp_state_t S_DONE     = 3'd4;

  // A one-pixel dimension still needs a 1-bit counter.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ray_dispatcher_raster_counter.sv
// Raster-order x/y position counter; holds at the final pixel until cleared.
module raster_counter
  import ray_dispatcher_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int X_W           = coord_w(SCREEN_WIDTH),
  parameter int Y_W           = coord_w(SCREEN_HEIGHT)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           i_clear,
  input  logic           i_advance,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end = (r_x == X_W'(SCREEN_WIDTH - 1));
  assign w_y_end = (r_y == Y_W'(SCREEN_HEIGHT - 1));
  assign o_last  = w_x_end && w_y_end;
  assign o_x     = r_x;
  assign o_y     = r_y;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance && !o_last) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Frame dispatcher: raster-scans the screen into the ray core input FIFO,
// waits for all fragments to be shaded, then pulses frame_done.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int X_W           = coord_w(SCREEN_WIDTH),
  parameter int Y_W           = coord_w(SCREEN_HEIGHT)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            abort,
  input  logic            fifo_full,
  input  logic [31:0]     pixel_counter,
  output logic            add_input,
  output SurfaceInputData input_data,
  output logic            reset_pixel_counter,
  output logic            busy,
  output logic            frame_done,
  output logic [31:0]     stall_cycles
);

  localparam logic [31:0] TOTAL_PIXELS = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);

  disp_state_t    r_state;
  disp_state_t    w_next;
  logic [31:0]    r_stall;
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  logic           w_last;
  logic           w_push;

  // Push decision uses fifo_full in the same cycle, so the FIFO can never overflow.
  assign w_push = (r_state == S_DISPATCH) && !fifo_full;

  raster_counter #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .X_W          (X_W),
    .Y_W          (Y_W)
  ) u_raster (
    .clk      (clk),
    .resetn   (resetn),
    .i_clear  (r_state == S_CLEAR),
    .i_advance(w_push),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_last   (w_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_CLEAR;
      S_CLEAR:    w_next = S_DISPATCH;
      S_DISPATCH: if (w_push && w_last) w_next = S_DRAIN;
      S_DRAIN:    if (pixel_counter >= TOTAL_PIXELS) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall <= '0;
    end else if (r_state == S_CLEAR) begin
      r_stall <= '0;
    end else if ((r_state == S_DISPATCH) && fifo_full && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  always_comb begin
    input_data   = '0;
    input_data.x = 16'(w_x);
    input_data.y = 16'(w_y);
  end

  assign add_input           = w_push;
  assign reset_pixel_counter = (r_state == S_CLEAR);
  assign frame_done          = (r_state == S_DONE);
  assign busy                = (r_state == S_CLEAR) || (r_state == S_DISPATCH) ||
                               (r_state == S_DRAIN);
  assign stall_cycles        = r_stall;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 screen: vector table plus
// hand-written backpressure, drain, abort, ignored-start and reset sequences.
module tb_ray_dispatcher;
  import ray_dispatcher_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            fifo_full = 1'b0;
  logic [31:0]     pixel_counter = '0;
  logic            add_input;
  SurfaceInputData input_data;
  logic            reset_pixel_counter;
  logic            busy;
  logic            frame_done;
  logic [31:0]     stall_cycles;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        start;
    logic        abort;
    logic        ff;
    logic [31:0] pc;
    logic        e_add;
    logic        e_rpc;
    logic        e_busy;
    logic        e_fd;
    int          e_x;
    int          e_y;
    int          e_stall;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  ray_dispatcher #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start),
    .abort              (abort),
    .fifo_full          (fifo_full),
    .pixel_counter      (pixel_counter),
    .add_input          (add_input),
    .input_data         (input_data),
    .reset_pixel_counter(reset_pixel_counter),
    .busy               (busy),
    .frame_done         (frame_done),
    .stall_cycles       (stall_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic void addv(input logic s, input logic a, input logic ff, input int pc,
                               input logic ad, input logic rp, input logic bs, input logic fd,
                               input int x, input int y, input int st);
    vec_t v;
    v.start = s;  v.abort = a;  v.ff = ff;  v.pc = pc;
    v.e_add = ad; v.e_rpc = rp; v.e_busy = bs; v.e_fd = fd;
    v.e_x = x;    v.e_y = y;    v.e_stall = st;
    vq.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int px, py, pushes, stalls, fds, bad;

    // Nominal frame, then start+abort together in IDLE.
    addv(1,0,0,0, 0,0,0,0, 0,0,0);
    addv(0,0,0,0, 0,1,1,0, 0,0,0);
    for (int i = 0; i < 8; i++) addv(0,0,0,0, 1,0,1,0, i % 4, i / 4, 0);
    addv(0,0,0,0, 0,0,1,0, 3,1,0);
    addv(0,0,0,8, 0,0,1,0, 3,1,0);
    addv(0,0,0,8, 0,0,0,1, 3,1,0);
    addv(0,0,0,8, 0,0,0,0, 3,1,0);
    addv(1,1,0,0, 0,0,0,0, 3,1,0);
    addv(0,0,0,0, 0,0,0,0, 3,1,0);

    repeat (2) @(posedge clk);
    #2;
    chk("rst add", 32'(add_input), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst rpc", 32'(reset_pixel_counter), 0);
    chk("rst done", 32'(frame_done), 0);
    chk("rst stall", stall_cycles, 0);
    chk("rst data zero", 32'(input_data == '0), 1);
    resetn = 1'b1;

    foreach (vq[i]) begin
      start = vq[i].start;
      abort = vq[i].abort;
      fifo_full = vq[i].ff;
      pixel_counter = vq[i].pc;
      #1;
      chk($sformatf("v%0d add", i), 32'(add_input), 32'(vq[i].e_add));
      chk($sformatf("v%0d rpc", i), 32'(reset_pixel_counter), 32'(vq[i].e_rpc));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
      chk($sformatf("v%0d done", i), 32'(frame_done), 32'(vq[i].e_fd));
      chk($sformatf("v%0d x", i), 32'(input_data.x), vq[i].e_x);
      chk($sformatf("v%0d y", i), 32'(input_data.y), vq[i].e_y);
      chk($sformatf("v%0d stall", i), stall_cycles, vq[i].e_stall);
      step();
    end
    start = 0; abort = 0; fifo_full = 0; pixel_counter = 0;

    // Backpressure on alternate DISPATCH cycles.
    start = 1; step(); start = 0;
    #1 chk("bp clear rpc", 32'(reset_pixel_counter), 1);
    step();
    px = 0; py = 0; pushes = 0; stalls = 0;
    for (int k = 0; k < 40 && pushes < 8; k++) begin
      fifo_full = k[0];
      #1;
      chk($sformatf("bp k%0d x", k), 32'(input_data.x), px);
      chk($sformatf("bp k%0d y", k), 32'(input_data.y), py);
      if (fifo_full) begin
        stalls++;
        chk($sformatf("bp k%0d add while full", k), 32'(add_input), 0);
      end else begin
        chk($sformatf("bp k%0d add", k), 32'(add_input), 1);
        pushes++;
        if (!(px == W - 1 && py == H - 1)) begin
          if (px == W - 1) begin px = 0; py++; end
          else px++;
        end
      end
      step();
    end
    fifo_full = 0;
    chk("bp pushes", pushes, 8);
    chk("bp model stalls", stalls, 7);
    #1;
    chk("bp stall_cycles", stall_cycles, 7);
    chk("bp drain busy", 32'(busy), 1);
    chk("bp drain add", 32'(add_input), 0);

    // DRAIN holds while the core is one fragment short.
    pixel_counter = 7;
    bad = 0;
    repeat (100) begin
      #1;
      if (!busy || frame_done || add_input) bad++;
      step();
    end
    chk("drain hold bad cycles", bad, 0);
    chk("drain stall kept", stall_cycles, 7);
    pixel_counter = 8;
    #1 chk("drain exit busy", 32'(busy), 1);
    step();
    #1 chk("drain done pulse", 32'(frame_done), 1);
    chk("done busy low", 32'(busy), 0);
    step();
    #1 chk("done pulse ends", 32'(frame_done), 0);
    pixel_counter = 0;

    // Abort after three pushes, the third in the abort cycle itself.
    start = 1; step(); start = 0;
    step();
    step();
    step();
    abort = 1;
    #1 chk("abort cycle push", 32'(add_input), 1);
    step();
    abort = 0;
    #1;
    chk("post abort add", 32'(add_input), 0);
    chk("post abort busy", 32'(busy), 0);
    chk("post abort rpc", 32'(reset_pixel_counter), 0);
    chk("post abort x", 32'(input_data.x), 3);
    bad = 0;
    repeat (5) begin
      #1;
      if (frame_done || add_input || busy) bad++;
      step();
    end
    chk("abort idle bad cycles", bad, 0);
    start = 1; step(); start = 0;
    #1 chk("restart rpc", 32'(reset_pixel_counter), 1);
    step();

    // Restarted frame: start pulses in DISPATCH and DONE must be ignored,
    // and a satisfied pixel_counter during DISPATCH must not end it early.
    pixel_counter = 8;
    pushes = 0; fds = 0;
    for (int k = 0; k < 20; k++) begin
      start = (k == 3 || k == 9);
      #1;
      if (k == 0) begin
        chk("restart x", 32'(input_data.x), 0);
        chk("restart y", 32'(input_data.y), 0);
      end
      if (add_input) pushes++;
      if (frame_done) begin
        fds++;
        chk("done cycle index", k, 9);
      end
      step();
    end
    start = 0; pixel_counter = 0;
    chk("ignored start pushes", pushes, 8);
    chk("ignored start done pulses", fds, 1);

    // Asynchronous reset in the middle of DISPATCH.
    start = 1; step(); start = 0;
    step();
    fifo_full = 1; step(); step();
    fifo_full = 0; step();
    #1;
    chk("pre-reset add", 32'(add_input), 1);
    chk("pre-reset stall", stall_cycles, 2);
    chk("pre-reset x", 32'(input_data.x), 1);
    #1 resetn = 0;
    #1;
    chk("async rst add", 32'(add_input), 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst stall", stall_cycles, 0);
    chk("async rst x", 32'(input_data.x), 0);
    chk("async rst y", 32'(input_data.y), 0);
    step();
    resetn = 1;
    step();
    #1 chk("after rst idle busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
